// File: rtl/bus_slave_pkg.sv
// rtl/bus_slave_pkg.sv - shared types and limits for the 8088 bus slave controller
package bus_slave_pkg;

  localparam int MAX_CH     = 8;
  localparam int MAX_WAIT   = 7;
  localparam int WAIT_W     = 3;
  localparam int MAX_ADDR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] base;
    logic                  is_io;
    logic [WAIT_W-1:0]     waits;
  } ch_cfg_t;

endpackage

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - combinational channel hit, one-hot select and local address
module bus_addr_decode
  import bus_slave_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int NUM_CH = 2,
  parameter int LOC_W  = 10
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              iom_i,
  input  ch_cfg_t           cfg_i [NUM_CH],
  output logic              hit_o,
  output logic [NUM_CH-1:0] sel_o,
  output logic [LOC_W-1:0]  loc_o,
  output logic [WAIT_W-1:0] waits_o
);

  logic [MAX_ADDR_W-1:0] addr_ext;

  // Bases are window-aligned, so a window match is an upper-bit compare.
  // Scanning downward lets the lowest index win on overlap.
  always_comb begin
    addr_ext = MAX_ADDR_W'(addr_i);
    hit_o    = 1'b0;
    sel_o    = '0;
    waits_o  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (((addr_ext >> LOC_W) == (cfg_i[i].base >> LOC_W)) && (cfg_i[i].is_io == iom_i)) begin
        hit_o    = 1'b1;
        sel_o    = '0;
        sel_o[i] = 1'b1;
        waits_o  = cfg_i[i].waits;
      end
    end
  end

  assign loc_o = addr_i[LOC_W-1:0];

endmodule

// File: rtl/bus_slave_ctrl.sv
// rtl/bus_slave_ctrl.sv - 8088 min-mode bus slave: latch, decode, wait states, read return
// Optional BUS_SLAVE_STATS_EN adds saturating read/write/miss counters.
module bus_slave_ctrl
  import bus_slave_pkg::*;
#(
  parameter int               ADDR_W           = 20,
  parameter int               NUM_CH           = 2,
  parameter int               LOC_W            = 10,
  parameter logic [ADDR_W-1:0] CH_BASE [NUM_CH] = '{20'h00000, 20'h00400},
  parameter logic [NUM_CH-1:0] CH_IS_IO         = 2'b10,
  parameter int               CH_WAIT [NUM_CH] = '{0, 2}
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                ALE,
  input  logic                RD,
  input  logic                WR,
  input  logic                IOM,
  input  logic [7:0]          AD,
  input  logic [ADDR_W-9:0]   A,
  output logic [7:0]          DOUT,
  output logic                OE,
  output logic                READY,
  output logic [NUM_CH-1:0]   CH_SEL,
  output logic [LOC_W-1:0]    CH_ADDR,
  output logic [7:0]          CH_WDATA,
  output logic                CH_WE,
  output logic                CH_RE,
  input  logic [NUM_CH*8-1:0] CH_RDATA,
  output logic                MISS
`ifdef BUS_SLAVE_STATS_EN
  ,
  output logic [15:0]         RD_CNT,
  output logic [15:0]         WR_CNT,
  output logic [15:0]         MISS_CNT
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              iom_q;
  logic              rd_q, rd_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              miss_q, miss_d;
  logic              miss_evt;
  logic              cap_q;
  logic [7:0]        dout_q;
  logic [7:0]        rd_slice;

  ch_cfg_t           cfg [NUM_CH];
  logic              dec_hit;
  logic [NUM_CH-1:0] dec_sel;
  logic [LOC_W-1:0]  dec_loc;
  logic [WAIT_W-1:0] dec_waits;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cfg
    assign cfg[g] = '{base:  MAX_ADDR_W'(CH_BASE[g]),
                      is_io: CH_IS_IO[g],
                      waits: WAIT_W'((CH_WAIT[g] > MAX_WAIT) ? MAX_WAIT : CH_WAIT[g])};
  end

  bus_addr_decode #(
    .ADDR_W (ADDR_W),
    .NUM_CH (NUM_CH),
    .LOC_W  (LOC_W)
  ) u_decode (
    .addr_i  (addr_q),
    .iom_i   (iom_q),
    .cfg_i   (cfg),
    .hit_o   (dec_hit),
    .sel_o   (dec_sel),
    .loc_o   (dec_loc),
    .waits_o (dec_waits)
  );

  always_comb begin
    rd_slice = '0;
    for (int i = 0; i < NUM_CH && i < MAX_CH; i++) begin
      if (dec_sel[i]) rd_slice = CH_RDATA[i*8 +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    wcnt_d   = wcnt_q;
    miss_evt = 1'b0;
    if (ALE) begin
      state_d = ST_ADDR;
      rd_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (!RD || !WR) begin
            // Both strobes low at once is illegal and handled like a decode miss.
            if (!dec_hit || (!RD && !WR)) begin
              miss_evt = 1'b1;
              rd_d     = 1'b0;
              state_d  = ST_DONE;
            end else begin
              rd_d    = !RD;
              wcnt_d  = dec_waits;
              state_d = (dec_waits == '0) ? ST_ACCESS : ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          wcnt_d = wcnt_q - WAIT_W'(1);
          if (wcnt_d == '0) state_d = ST_ACCESS;
        end
        ST_ACCESS: state_d = ST_DONE;
        ST_DONE:   if (RD && WR) state_d = ST_IDLE;
        default:   state_d = state_q;
      endcase
    end
    miss_d = miss_q | miss_evt;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      iom_q   <= 1'b0;
      rd_q    <= 1'b0;
      wcnt_q  <= '0;
      miss_q  <= 1'b0;
      cap_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wcnt_q  <= wcnt_d;
      miss_q  <= miss_d;
      if (ALE) begin
        addr_q <= {A, AD};
        iom_q  <= IOM;
      end
      cap_q <= (state_q == ST_ACCESS) && (state_d == ST_DONE) && rd_q;
      if (cap_q) dout_q <= rd_slice;
    end
  end

  // Back-end read data is only valid in the first DONE cycle, so it is
  // passed straight through then and held from the register afterwards.
  assign DOUT     = cap_q ? rd_slice : dout_q;
  assign OE       = (state_q == ST_DONE) && rd_q && !RD;
  assign READY    = (state_q != ST_WAIT);
  assign CH_WE    = (state_q == ST_ACCESS) && !rd_q;
  assign CH_RE    = (state_q == ST_ACCESS) && rd_q;
  assign CH_WDATA = CH_WE ? AD : 8'h00;
  assign CH_SEL   = (state_q != ST_IDLE) ? dec_sel : '0;
  assign CH_ADDR  = dec_loc;
  assign MISS     = miss_q;

`ifdef BUS_SLAVE_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (CH_RE && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (CH_WE && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (miss_evt && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign RD_CNT   = rd_cnt_q;
  assign WR_CNT   = wr_cnt_q;
  assign MISS_CNT = miss_cnt_q;
`endif

endmodule
